// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the instruction decode stage:
//   - major opcode constants (bits [6:0] of the instruction word)
//   - bit positions of each class inside the one-hot decoded vector
//   - the four fixed SYSTEM instruction words (ecall/ebreak/mret/wfi)
//   - the bundle carried through the stage registers
//   - a helper that recognises the supported AMO funct5 encodings
// No ports (package).
// ---------------------------------------------------------------------------
package decode_stage_pkg;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_AMO    = 7'b0101111;

    localparam int CLASS_W    = 12;
    localparam int CLS_RTYPE  = 11;
    localparam int CLS_ITYPE  = 10;
    localparam int CLS_LOAD   = 9;
    localparam int CLS_STORE  = 8;
    localparam int CLS_BRANCH = 7;
    localparam int CLS_JAL    = 6;
    localparam int CLS_JALR   = 5;
    localparam int CLS_LUI    = 4;
    localparam int CLS_AUIPC  = 3;
    localparam int CLS_SYSTEM = 2;
    localparam int CLS_FENCE  = 1;
    localparam int CLS_AMO    = 0;

    localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] SYS_MRET   = 32'h3020_0073;
    localparam logic [31:0] SYS_WFI    = 32'h1050_0073;

    // Everything the stage hands downstream for one instruction.
    typedef struct packed {
        logic [31:0]        instr;
        logic [31:0]        pc;
        logic [CLASS_W-1:0] decoded;
        logic               illegal;
        logic               ecall;
        logic               ebreak;
        logic               mret;
        logic               wfi;
        logic               csr;
    } decode_bundle_t;

    // LR, SC, AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR, AMOMIN/MAX(U).
    function automatic logic amoFunct5Ok(input logic [4:0] funct5);
        case (funct5)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
            5'b01000, 5'b01100, 5'b10000, 5'b10100, 5'b11000,
            5'b11100: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// ---------------------------------------------------------------------------
// decode_comb
// Purely combinational instruction classifier.
// Ports:
//   i_instr    32-bit instruction word
//   o_decoded  one-hot class vector (zero when illegal)
//   o_illegal  encoding not supported by this core configuration
//   o_ecall, o_ebreak, o_mret, o_wfi, o_csr
//              SYSTEM sub-decode, only ever set for a legal SYSTEM word
// Parameters EN_M / EN_A / EN_ZICSR enable the M, A and Zicsr extensions.
// ---------------------------------------------------------------------------
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit EN_M     = 1'b1,
    parameter bit EN_A     = 1'b1,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]        i_instr,
    output logic [CLASS_W-1:0] o_decoded,
    output logic               o_illegal,
    output logic               o_ecall,
    output logic               o_ebreak,
    output logic               o_mret,
    output logic               o_wfi,
    output logic               o_csr
);

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [4:0]         w_funct5;
    logic [4:0]         w_rs2;
    logic [CLASS_W-1:0] w_class;
    logic               w_illegal;
    logic               w_ecall;
    logic               w_ebreak;
    logic               w_mret;
    logic               w_wfi;
    logic               w_csr;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_funct5 = i_instr[31:27];
    assign w_rs2    = i_instr[24:20];

    // The opcode compare covers instr[1:0] too, so a compressed-looking
    // word (low bits != 11) falls into the default and is flagged illegal.
    always_comb begin
        w_class   = '0;
        w_illegal = 1'b0;
        w_ecall   = 1'b0;
        w_ebreak  = 1'b0;
        w_mret    = 1'b0;
        w_wfi     = 1'b0;
        w_csr     = 1'b0;
        case (w_opcode)
            OPCODE_RTYPE: begin
                w_class[CLS_RTYPE] = 1'b1;
                case (w_funct7)
                    7'b0000000: w_illegal = 1'b0;
                    7'b0100000: w_illegal = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
                    7'b0000001: w_illegal = !EN_M;
                    default:    w_illegal = 1'b1;
                endcase
            end
            OPCODE_ITYPE: begin
                w_class[CLS_ITYPE] = 1'b1;
                if (w_funct3 == 3'b001) begin
                    w_illegal = (w_funct7 != 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_illegal = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
                end
            end
            OPCODE_LOAD: begin
                w_class[CLS_LOAD] = 1'b1;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            OPCODE_STORE: begin
                w_class[CLS_STORE] = 1'b1;
                w_illegal = (w_funct3 >= 3'b011);
            end
            OPCODE_BRANCH: begin
                w_class[CLS_BRANCH] = 1'b1;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPCODE_JAL: begin
                w_class[CLS_JAL] = 1'b1;
            end
            OPCODE_JALR: begin
                w_class[CLS_JALR] = 1'b1;
                w_illegal = (w_funct3 != 3'b000);
            end
            OPCODE_LUI: begin
                w_class[CLS_LUI] = 1'b1;
            end
            OPCODE_AUIPC: begin
                w_class[CLS_AUIPC] = 1'b1;
            end
            OPCODE_FENCE: begin
                w_class[CLS_FENCE] = 1'b1;
                w_illegal = !(w_funct3 == 3'b000 || w_funct3 == 3'b001);
            end
            OPCODE_AMO: begin
                w_class[CLS_AMO] = 1'b1;
                // LR (funct5 00010) has no rs2 operand, so a non-zero rs2 is reserved.
                w_illegal = !EN_A || (w_funct3 != 3'b010) || !amoFunct5Ok(w_funct5)
                          || ((w_funct5 == 5'b00010) && (w_rs2 != 5'd0));
            end
            OPCODE_SYSTEM: begin
                w_class[CLS_SYSTEM] = 1'b1;
                if (w_funct3 == 3'b000) begin
                    // funct3=000 only has four fixed encodings; every other bit must match.
                    case (i_instr)
                        SYS_ECALL:  w_ecall  = 1'b1;
                        SYS_EBREAK: w_ebreak = 1'b1;
                        SYS_MRET:   w_mret   = 1'b1;
                        SYS_WFI:    w_wfi    = 1'b1;
                        default:    w_illegal = 1'b1;
                    endcase
                end else if (w_funct3 == 3'b100) begin
                    w_illegal = 1'b1;
                end else begin
                    w_csr     = 1'b1;
                    w_illegal = !EN_ZICSR;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Illegal words carry no class and no sideband flags.
    assign o_decoded = w_illegal ? '0 : w_class;
    assign o_illegal = w_illegal;
    assign o_ecall   = w_ecall  & !w_illegal;
    assign o_ebreak  = w_ebreak & !w_illegal;
    assign o_mret    = w_mret   & !w_illegal;
    assign o_wfi     = w_wfi    & !w_illegal;
    assign o_csr     = w_csr    & !w_illegal;

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered decode stage between fetch and register read. Each accepted
// instruction is classified by decode_comb and appears on the outputs one
// cycle later together with its PC. Illegal words are not dropped.
// Ports:
//   clk_in, rst_n_in      clock / asynchronous active-low reset
//   flush_in              kill everything held in the stage
//   valid_in, ready_out   upstream handshake; instr_in, pc_in payload
//   valid_out, ready_in   downstream handshake
//   instr_out, pc_out     registered instruction and PC
//   decoded_out           one-hot class {RTYPE..AMO}, bits 11..0
//   illegal_ins_out       illegal encoding
//   ecall_out, ebreak_out, mret_out, wfi_out, csr_out   SYSTEM sub-decode
// SKID=1 adds a one-entry skid buffer so ready_out comes straight from a flop.
// ---------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit EN_M     = 1'b1,
    parameter bit EN_A     = 1'b1,
    parameter bit EN_ZICSR = 1'b1,
    parameter bit SKID     = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               flush_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [31:0]        instr_in,
    input  logic [31:0]        pc_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc_out,
    output logic [CLASS_W-1:0] decoded_out,
    output logic               illegal_ins_out,
    output logic               ecall_out,
    output logic               ebreak_out,
    output logic               mret_out,
    output logic               wfi_out,
    output logic               csr_out
);

    decode_bundle_t w_in;
    decode_bundle_t r_out;
    logic           r_outValid;

    assign w_in.instr = instr_in;
    assign w_in.pc    = pc_in;

    decode_comb #(
        .EN_M     (EN_M),
        .EN_A     (EN_A),
        .EN_ZICSR (EN_ZICSR)
    ) u_decode_comb (
        .i_instr   (instr_in),
        .o_decoded (w_in.decoded),
        .o_illegal (w_in.illegal),
        .o_ecall   (w_in.ecall),
        .o_ebreak  (w_in.ebreak),
        .o_mret    (w_in.mret),
        .o_wfi     (w_in.wfi),
        .o_csr     (w_in.csr)
    );

    generate
        if (SKID) begin : g_skid
            decode_bundle_t r_skid;
            logic           r_skValid;
            logic           r_ready;
            logic           w_accept;
            logic           w_outFree;
            logic           w_outValidNext;
            logic           w_skValidNext;
            logic           w_loadOutFromSkid;
            logic           w_loadOutFromIn;
            logic           w_loadSkid;

            assign w_accept  = valid_in & r_ready;
            assign w_outFree = !r_outValid | ready_in;

            // The skid entry is always older than anything arriving now, so it
            // drains into the output register first; while it is full r_ready
            // is low and no new beat can compete with it.
            always_comb begin
                w_outValidNext    = r_outValid;
                w_skValidNext     = r_skValid;
                w_loadOutFromSkid = 1'b0;
                w_loadOutFromIn   = 1'b0;
                w_loadSkid        = 1'b0;
                if (flush_in) begin
                    w_outValidNext = 1'b0;
                    w_skValidNext  = 1'b0;
                end else if (w_outFree) begin
                    if (r_skValid) begin
                        w_outValidNext    = 1'b1;
                        w_skValidNext     = 1'b0;
                        w_loadOutFromSkid = 1'b1;
                    end else if (w_accept) begin
                        w_outValidNext  = 1'b1;
                        w_loadOutFromIn = 1'b1;
                    end else begin
                        w_outValidNext = 1'b0;
                    end
                end else if (w_accept) begin
                    w_skValidNext = 1'b1;
                    w_loadSkid    = 1'b1;
                end
            end

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_outValid <= 1'b0;
                    r_out      <= '0;
                    r_skValid  <= 1'b0;
                    r_skid     <= '0;
                    r_ready    <= 1'b1;
                end else begin
                    r_outValid <= w_outValidNext;
                    r_skValid  <= w_skValidNext;
                    r_ready    <= !w_skValidNext;
                    if (w_loadOutFromSkid) begin
                        r_out <= r_skid;
                    end else if (w_loadOutFromIn) begin
                        r_out <= w_in;
                    end
                    if (w_loadSkid) begin
                        r_skid <= w_in;
                    end
                end
            end

            assign ready_out = r_ready;
        end else begin : g_noskid
            logic w_accept;

            assign ready_out = !r_outValid | ready_in;
            assign w_accept  = valid_in & ready_out;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_outValid <= 1'b0;
                    r_out      <= '0;
                end else if (flush_in) begin
                    r_outValid <= 1'b0;
                end else if (w_accept) begin
                    r_outValid <= 1'b1;
                    r_out      <= w_in;
                end else if (ready_in) begin
                    r_outValid <= 1'b0;
                end
            end
        end
    endgenerate

    assign valid_out       = r_outValid;
    assign instr_out       = r_out.instr;
    assign pc_out          = r_out.pc;
    assign decoded_out     = r_out.decoded;
    assign illegal_ins_out = r_out.illegal;
    assign ecall_out       = r_out.ecall;
    assign ebreak_out      = r_out.ebreak;
    assign mret_out        = r_out.mret;
    assign wfi_out         = r_out.wfi;
    assign csr_out         = r_out.csr;

endmodule
